// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one outstanding imem request at a time,
// returned {pc, inst} pairs buffered in a small FIFO for the decode stage.
module inst_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  pause,
    input  logic        flush,
    input  logic [31:0] pc_i,
    input  logic        inst_en_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic        inst_rvalid_i,
    input  logic [31:0] inst_rdata_i,
    output logic        pause_request_o,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    // state  | meaning
    // IDLE   | free to issue a request
    // WAIT   | request accepted, response pending, will be queued
    // DRAIN  | response pending but flushed, will be discarded
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pending_pc_q;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // pause[0] is our own stall request fed back; only the ID stall matters here
    logic unused_pause;
    assign unused_pause = ^{pause[5:2], pause[0]};

    assign inst_req_o      = (state_q == S_IDLE) && inst_en_i && !flush && (count_q < FULL_CNT);
    assign inst_addr_o     = inst_req_o ? pc_i : 32'd0;
    assign accept          = inst_req_o && inst_ack_i;
    assign pause_request_o = inst_en_i && !accept;

    assign id_valid_o = (count_q != '0);
    assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr_q]   : 32'd0;
    assign id_inst_o  = id_valid_o ? inst_mem[rd_ptr_q] : 32'd0;

    assign push = !flush && (state_q == S_WAIT) && inst_rvalid_i;
    assign pop  = !flush && id_valid_o && !pause[1];

    always_comb begin
        state_d = state_q;
        if (flush) begin
            // a response landing in the flush cycle itself closes the transaction
            if (state_q != S_IDLE) begin
                state_d = inst_rvalid_i ? S_IDLE : S_DRAIN;
            end
        end else begin
            case (state_q)
                S_IDLE:  if (accept)        state_d = S_WAIT;
                S_WAIT:  if (inst_rvalid_i) state_d = S_IDLE;
                S_DRAIN: if (inst_rvalid_i) state_d = S_IDLE;
                default:                    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + (PW+1)'(1);
            else if (pop && !push) count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (accept) pending_pc_q <= pc_i;
            if (push) begin
                pc_mem[wr_ptr_q]   <= pending_pc_q;
                inst_mem[wr_ptr_q] <= inst_rdata_i;
            end
        end
    end

endmodule
